// File: rtl/geiger_stack_reader.sv
// Receiver for the geiger stack byte bus: hunts for the sync byte, collects the
// payload, verifies the XOR checksum and hands the record to the logger.
`timescale 1ns/1ps
module geiger_stack_reader #(
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         PAYLOAD_BYTES  = 6,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic                         CLK_1MHZ,
   input  logic                         RESET,
   input  logic [7:0]                   D_IN,
   input  logic                         D_VALID,
   output logic                         D_READY,
   output logic [8*PAYLOAD_BYTES-1:0]   RECORD,
   output logic                         RECORD_VALID,
   input  logic                         RECORD_ACK,
   output logic                         CHK_ERR,
   output logic                         TIMEOUT_ERR,
   output logic [15:0]                  RECORD_COUNT,
   output logic [7:0]                   ERROR_COUNT
);

   localparam int REC_W = 8 * PAYLOAD_BYTES;
   localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
   localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK, HOLD} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [7:0]       xsum;
   logic [GAP_W-1:0] gap;
   logic [REC_W-1:0] sreg;
   logic             xfer;

   assign xfer = D_VALID && D_READY;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge CLK_1MHZ) begin
      if (RESET) begin
         state        <= HUNT;
         idx          <= '0;
         xsum         <= '0;
         gap          <= '0;
         D_READY      <= 1'b1;
         RECORD       <= '0;
         RECORD_VALID <= 1'b0;
         CHK_ERR      <= 1'b0;
         TIMEOUT_ERR  <= 1'b0;
         RECORD_COUNT <= '0;
         ERROR_COUNT  <= '0;
      end else begin
         CHK_ERR     <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         case (state)
            HUNT: begin
               if (xfer && D_IN == SYNC_BYTE) begin
                  state <= PAYLOAD;
                  idx   <= '0;
                  xsum  <= '0;
                  gap   <= '0;
               end
            end
            PAYLOAD: begin
               // Sync value inside the payload is plain data; no resync here.
               if (xfer) begin
                  sreg <= {sreg[REC_W-9:0], D_IN};
                  xsum <= xsum ^ D_IN;
                  gap  <= '0;
                  idx  <= idx + 1'b1;
                  if (idx == LAST_IDX)
                     state <= CHECK;
               end else if (gap == GAP_LAST) begin
                  TIMEOUT_ERR <= 1'b1;
                  ERROR_COUNT <= sat_inc8(ERROR_COUNT);
                  state       <= HUNT;
               end else begin
                  gap <= gap + 1'b1;
               end
            end
            CHECK: begin
               if (xfer) begin
                  if (D_IN == xsum) begin
                     RECORD       <= sreg;
                     RECORD_VALID <= 1'b1;
                     RECORD_COUNT <= RECORD_COUNT + 16'd1;
                     D_READY      <= 1'b0;
                     state        <= HOLD;
                  end else begin
                     CHK_ERR     <= 1'b1;
                     ERROR_COUNT <= sat_inc8(ERROR_COUNT);
                     state       <= HUNT;
                  end
               end else if (gap == GAP_LAST) begin
                  TIMEOUT_ERR <= 1'b1;
                  ERROR_COUNT <= sat_inc8(ERROR_COUNT);
                  state       <= HUNT;
               end else begin
                  gap <= gap + 1'b1;
               end
            end
            HOLD: begin
               // Stack stays back-pressured until the logger takes the record.
               if (RECORD_ACK && RECORD_VALID) begin
                  RECORD_VALID <= 1'b0;
                  D_READY      <= 1'b1;
                  state        <= HUNT;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_geiger_stack_reader.sv
// Randomized frame-level bench for geiger_stack_reader with a scoreboard model
// predicting record delivery, checksum errors, timeouts and counters.
`timescale 1ns/1ps
module tb_geiger_stack_reader;

   localparam logic [7:0] SYNC = 8'hA5;
   localparam int         TO   = 64;

   logic        clk;
   logic        rst;
   logic [7:0]  d_in;
   logic        d_valid;
   logic        d_ready;
   logic [47:0] record;
   logic        record_valid;
   logic        record_ack;
   logic        chk_err;
   logic        timeout_err;
   logic [15:0] record_count;
   logic [7:0]  error_count;

   geiger_stack_reader #(.SYNC_BYTE(SYNC), .PAYLOAD_BYTES(6), .TIMEOUT_CYCLES(TO)) dut (
      .CLK_1MHZ     (clk),
      .RESET        (rst),
      .D_IN         (d_in),
      .D_VALID      (d_valid),
      .D_READY      (d_ready),
      .RECORD       (record),
      .RECORD_VALID (record_valid),
      .RECORD_ACK   (record_ack),
      .CHK_ERR      (chk_err),
      .TIMEOUT_ERR  (timeout_err),
      .RECORD_COUNT (record_count),
      .ERROR_COUNT  (error_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_rec  = 0;
   int exp_err  = 0;
   int exp_chk  = 0;
   int exp_to   = 0;
   int seen_chk = 0;
   int seen_to  = 0;
   bit mon_en   = 1'b0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
   endtask

   function automatic logic [7:0] sat8(input int e);
      return (e > 255) ? 8'hFF : 8'(e);
   endfunction

   function automatic logic [7:0] xor_of(input logic [47:0] pl);
      logic [7:0] x = 8'h00;
      for (int j = 0; j < 6; j++) x = x ^ pl[47-8*j -: 8];
      return x;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      d_valid = 1'b0;
      repeat (n) begin
         d_in = 8'($urandom);
         tick();
      end
   endtask

   task automatic put(input logic [7:0] b);
      d_valid = 1'b1;
      d_in    = b;
      tick();
      d_valid = 1'b0;
   endtask

   task automatic junk();
      logic [7:0] b;
      b = 8'($urandom);
      if (b == SYNC) b = 8'h3C;
      record_ack = 1'($urandom_range(0, 1));
      put(b);
      record_ack = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_rdy"},  d_ready,      1);
      check({tag, "_rec"},  record,       0);
      check({tag, "_rv"},   record_valid, 0);
      check({tag, "_chk"},  chk_err,      0);
      check({tag, "_to"},   timeout_err,  0);
      check({tag, "_rcnt"}, record_count, 0);
      check({tag, "_ecnt"}, error_count,  0);
   endtask

   task automatic do_reset(input string tag);
      d_valid    = 1'b0;
      record_ack = 1'b0;
      rst        = 1'b1;
      tick();
      check_reset_state(tag);
      rst     = 1'b0;
      exp_rec = 0;
      exp_err = 0;
   endtask

   // gap_at: byte index (0..5 payload, 6 checksum) preceded by gap_len idle cycles.
   // ack_delay < 0 leaves a good record unacknowledged.
   task automatic send_frame(input logic [47:0] pl, input logic [7:0] ck,
                             input int gap_at, input int gap_len, input int ack_delay);
      put(SYNC);
      for (int i = 0; i < 7; i++) begin
         int g;
         g = (i == gap_at) ? gap_len : int'($urandom_range(0, 3));
         if (g >= TO) begin
            idle(TO - 1);
            check("to_early", timeout_err, 0);
            idle(1);
            exp_err++;
            exp_to++;
            check("to_pulse", timeout_err, 1);
            check("to_ecnt", error_count, sat8(exp_err));
            idle(1);
            check("to_once", timeout_err, 0);
            return;
         end
         idle(g);
         put(i < 6 ? pl[47-8*i -: 8] : ck);
      end
      if (ck == xor_of(pl)) begin
         exp_rec++;
         check("rv_rise", record_valid, 1);
         check("record",  record, pl);
         check("rec_cnt", record_count, 16'(exp_rec));
         check("hold_rdy0", d_ready, 0);
         check("good_chk", chk_err, 0);
         if (ack_delay >= 0) begin
            repeat (ack_delay) begin
               d_valid = 1'($urandom_range(0, 1));
               d_in    = 8'($urandom);
               tick();
               check("rec_stable", record, pl);
               check("rv_held", record_valid, 1);
            end
            d_valid    = 1'b0;
            record_ack = 1'b1;
            tick();
            record_ack = 1'b0;
            check("ack_rv", record_valid, 0);
            check("ack_rdy", d_ready, 1);
            check("ack_rec", record, pl);
         end
      end else begin
         exp_err++;
         exp_chk++;
         check("chk_pulse", chk_err, 1);
         check("chk_rv", record_valid, 0);
         check("chk_ecnt", error_count, sat8(exp_err));
         idle(1);
         check("chk_once", chk_err, 0);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("err_excl", chk_err & timeout_err, 0);
         if (record_valid) check("hold_rdy", d_ready, 0);
         if (chk_err) seen_chk++;
         if (timeout_err) seen_to++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time %0t, limit reached", $time);
      $fatal(1);
   end

   initial begin
      logic [47:0] pl;
      logic [7:0]  ck;
      int          gat;
      int          glen;
      rst        = 1'b1;
      d_in       = 8'h00;
      d_valid    = 1'b0;
      record_ack = 1'b0;
      tick();
      tick();
      check_reset_state("reset");
      rst    = 1'b0;
      mon_en = 1'b1;

      send_frame(48'h010203040506, 8'h07, -1, 0, 2);
      send_frame(48'h010203040506, 8'h00, -1, 0, 0);
      send_frame(48'h010203040506, 8'h07, -1, 0, 0);
      put(8'h00); put(8'hFF); put(8'h3C);
      send_frame(48'h010203040506, 8'h07, -1, 0, 20);
      send_frame(48'h010203040506, 8'h07, 2, 64, 0);
      send_frame(48'h010203040506, 8'h07, 2, 63, 1);
      send_frame(48'h010203040506, 8'h07, 6, 64, 0);
      send_frame(48'hA50000000001, 8'hA4, -1, 0, 1);

      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 3)) junk();
         for (int b = 0; b < 6; b++)
            pl[47-8*b -: 8] = ($urandom_range(0, 4) == 0) ? SYNC : 8'($urandom);
         ck   = xor_of(pl);
         if ($urandom_range(0, 3) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
         gat  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : -1;
         glen = int'($urandom_range(60, 70));
         send_frame(pl, ck, gat, glen, int'($urandom_range(0, 5)));
      end

      put(SYNC); put(8'h11); put(8'h22);
      do_reset("rst_payload");
      send_frame(48'h0A0B0C0D0E0F, xor_of(48'h0A0B0C0D0E0F), -1, 0, -1);
      check("pre_rst_cnt", record_count, 1);
      do_reset("rst_hold");
      send_frame(48'h123456789ABC, xor_of(48'h123456789ABC), -1, 0, 0);

      for (int f = 0; f < 256; f++) begin
         pl = {$urandom, 16'($urandom)};
         send_frame(pl, xor_of(pl) ^ 8'h80, -1, 0, 0);
      end
      check("err_sat", error_count, 8'hFF);
      send_frame(48'h010203040506, 8'h07, 4, 64, 0);
      check("err_sat_hold", error_count, 8'hFF);

      idle(2);
      check("chk_pulses", seen_chk, exp_chk);
      check("to_pulses", seen_to, exp_to);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/geiger_stack_reader.md
Name: geiger_stack_reader

Overview:
- Receiving end of the geiger stack byte bus. The stack drives records out as bytes on its D0..D7 lanes; this block takes those bytes in.
- Each frame is one sync byte, a 48-bit payload sent MSB byte first, and an XOR checksum byte.
- The block hunts for the sync byte, collects the 6 payload bytes, checks the checksum and presents the 48-bit record to the downstream logger with a valid/ack handshake.
- It sits between the stack output and the telemetry formatter, in the same 1 MHz domain.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- PAYLOAD_BYTES, 6, payload bytes per frame (record width = 8*PAYLOAD_BYTES).
- TIMEOUT_CYCLES, 64, maximum idle gap between bytes inside a frame before the frame is aborted.

Ports:
- CLK_1MHZ  in  1  system clock, 1 MHz.
- RESET  in  1  synchronous, active-high reset.
- D_IN  in  8  byte from the stack (D7..D0 = D_IN[7:0]).
- D_VALID  in  1  D_IN is valid this cycle.
- D_READY  out  1  reader accepts a byte this cycle.
- RECORD  out  48  assembled payload; first byte received lands in [47:40].
- RECORD_VALID  out  1  RECORD is valid; held until acknowledged.
- RECORD_ACK  in  1  downstream consumes RECORD.
- CHK_ERR  out  1  one-cycle pulse when a frame fails its checksum.
- TIMEOUT_ERR  out  1  one-cycle pulse when a frame is aborted on a byte gap.
- RECORD_COUNT  out  16  good records delivered; wraps at 16'hFFFF->0.
- ERROR_COUNT  out  8  checksum errors plus timeouts; saturates at 8'hFF.

Behaviour:
- Byte transfer occurs on a rising edge where D_VALID && D_READY.
- Reset values:
  - D_READY=1, RECORD=0, RECORD_VALID=0, CHK_ERR=0, TIMEOUT_ERR=0, RECORD_COUNT=0, ERROR_COUNT=0.
  - State=HUNT, byte index=0, running XOR=0, gap counter=0.
- RESET asserted mid-frame or mid-hold discards all partial and held data and returns every output to its reset value on the next edge.
- HUNT:
  - D_READY=1. Non-sync bytes are accepted and dropped.
  - SYNC_BYTE -> PAYLOAD; clear index, XOR and gap counter.
- PAYLOAD:
  - D_READY=1. Each byte is shifted into the shift register MSB first, XOR is updated and index increments.
  - The gap counter resets on each transfer and increments on idle cycles.
  - After byte PAYLOAD_BYTES-1 -> CHECK.
  - A byte equal to SYNC_BYTE is treated as payload data, not a resync.
- CHECK (waiting for the checksum byte):
  - D_READY=1. Gap counter applies as in PAYLOAD.
  - On transfer, if byte == XOR of the payload bytes: load RECORD from the shift register, RECORD_VALID=1 on the next edge, RECORD_COUNT+1, go to HOLD.
  - Otherwise: CHK_ERR pulses 1 cycle, ERROR_COUNT+1 (saturating), go to HUNT.
- HOLD:
  - D_READY=0; the stack is back-pressured.
  - RECORD_ACK while RECORD_VALID -> RECORD_VALID=0 and go to HUNT; D_READY=1 on the following cycle.
  - RECORD holds its last value after ack.
  - RECORD_ACK with RECORD_VALID=0 is ignored.
- Timeout:
  - In PAYLOAD or CHECK, when the gap counter reaches TIMEOUT_CYCLES with no transfer: TIMEOUT_ERR pulses, ERROR_COUNT+1, go to HUNT.
  - A transfer on the same cycle the count would expire wins; no timeout is raised.
- Latency: RECORD_VALID rises 1 cycle after the checksum byte is transferred.
- Throughput: minimum frame period is 8 bytes plus 1 ack cycle.
- CHK_ERR and TIMEOUT_ERR are registered and never asserted together.

Test Plan:
1. Send A5, 01 02 03 04 05 06, checksum 07 -> RECORD=48'h010203040506, RECORD_VALID=1 one cycle after the checksum byte, RECORD_COUNT=1, no error pulse.
2. Same frame with checksum 00 -> CHK_ERR pulses once, ERROR_COUNT=1, RECORD_VALID stays 0, state returns to HUNT. A following good frame is delivered normally.
3. Send leading junk 00 FF 3C, then the good frame, and hold RECORD_ACK low for 20 cycles -> junk is ignored; D_READY=0 for the whole hold; RECORD is stable; after ack, D_READY=1 on the next cycle.
4. Send A5 01 02, then idle 64 cycles -> TIMEOUT_ERR pulses on cycle 64 of the gap, ERROR_COUNT increments, HUNT. Repeat the frame with the next byte arriving at gap cycle 63 -> no timeout.
5. Payload containing A5 (A5, A5 00 00 00 00 01, checksum A4) -> RECORD=48'hA50000000001, no resync.
6. Assert RESET in mid-PAYLOAD and again during HOLD -> all outputs return to reset values. Force 256 bad frames -> ERROR_COUNT saturates at 8'hFF.
